// File: rtl/mul_div_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_pkg : shared encodings for the iterative multiply/divide unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mul_div_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_div_ctrl.sv
// ---------------------------------------------------------------------------
// mul_div_ctrl : sequencing FSM and step counter for mul_div_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_ctrl
  import mul_div_pkg::*;
(
  input  logic clock,
  input  logic clear,
  input  logic start,
  output logic busy,
  output logic load,
  output logic step,
  output logic fix,
  output logic finish
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(ITER_COUNT - 1);
          state_d = ITER;
        end
      end
      ITER: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        fix     = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // DONE still counts as busy so that busy drops on the same edge done rises
  assign busy = (state_q != IDLE);

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit : 32-step signed Booth multiply / non-restoring divide
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             div_by_zero
);

  logic load, step, fix, finish;

  mul_div_ctrl u_ctrl (
    .clock  (clock),
    .clear  (clear),
    .start  (start),
    .busy   (busy),
    .load   (load),
    .step   (step),
    .fix    (fix),
    .finish (finish)
  );

  // hi is one bit wider than an operand: Booth needs it to subtract the most
  // negative multiplicand, the divider needs it as the remainder sign.
  logic             op_q,     op_d;
  logic             a_neg_q,  a_neg_d;
  logic             b_neg_q,  b_neg_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] a_raw_q,  a_raw_d;
  logic [WIDTH:0]   m_q,      m_d;
  logic [WIDTH:0]   hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             qm1_q,    qm1_d;
  logic [WIDTH-1:0] z_hi_q,   z_hi_d;
  logic [WIDTH-1:0] z_lo_q,   z_lo_d;
  logic             dbz_q,    dbz_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   booth_sum, r_shift, r_next, rem_fix;

  always_ff @(posedge clock) begin
    if (clear) begin
      op_q     <= OP_MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      z_hi_q   <= '0;
      z_lo_q   <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
      a_raw_q  <= a_raw_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      z_hi_q   <= z_hi_d;
      z_lo_q   <= z_lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    op_d      = op_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    b_zero_d  = b_zero_q;
    a_raw_d   = a_raw_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    qm1_d     = qm1_q;
    z_hi_d    = z_hi_q;
    z_lo_d    = z_lo_q;
    dbz_d     = dbz_q;
    done_d    = finish;
    booth_sum = '0;
    r_shift   = '0;
    r_next    = '0;
    rem_fix   = '0;

    abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

    if (load) begin
      op_d     = op;
      a_neg_d  = operand_a[WIDTH-1];
      b_neg_d  = operand_b[WIDTH-1];
      b_zero_d = (operand_b == '0);
      a_raw_d  = operand_a;
      hi_d     = '0;
      qm1_d    = 1'b0;
      if (op == OP_MUL) begin
        m_d  = {operand_a[WIDTH-1], operand_a};
        lo_d = operand_b;
      end else begin
        m_d  = {1'b0, abs_b};
        lo_d = abs_a;
      end
    end else if (step) begin
      if (op_q == OP_MUL) begin
        case ({lo_q[0], qm1_q})
          2'b01:   booth_sum = hi_q + m_q;
          2'b10:   booth_sum = hi_q - m_q;
          default: booth_sum = hi_q;
        endcase
        hi_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
        qm1_d = lo_q[0];
      end else begin
        r_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        r_next  = hi_q[WIDTH] ? (r_shift + m_q) : (r_shift - m_q);
        hi_d    = r_next;
        lo_d    = {lo_q[WIDTH-2:0], ~r_next[WIDTH]};
      end
    end else if (fix) begin
      if (op_q == OP_DIV) begin
        rem_fix = hi_q[WIDTH] ? (hi_q + m_q) : hi_q;
        if (b_zero_q) begin
          hi_d = {a_raw_q[WIDTH-1], a_raw_q};
          lo_d = '1;
        end else begin
          // Truncating division: remainder follows the dividend's sign
          hi_d = a_neg_q ? -rem_fix : rem_fix;
          lo_d = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
        end
      end
    end

    if (finish) begin
      z_hi_d = hi_q[WIDTH-1:0];
      z_lo_d = lo_q;
      dbz_d  = (op_q == OP_DIV) && b_zero_q;
    end
  end

  assign done        = done_q;
  assign z_hi        = z_hi_q;
  assign z_lo        = z_lo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit : directed vector bench for mul_div_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic         op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [W-1:0] z_hi;
  logic [W-1:0] z_lo;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] prev_hi, prev_lo;
  logic         prev_dbz;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .z_hi        (z_hi),
    .z_lo        (z_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; start is sampled on the following edge.
  task automatic launch(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_low_after_start", done, 0);
    check("z_hi_hold", z_hi, prev_hi);
    check("z_lo_hold", z_lo, prev_lo);
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!done && lat < 60);
    check({tag, "_latency"}, lat, 34);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic expect_pulse_end(input string tag);
    @(posedge clock); #1;
    check({tag, "_done_pulse_end"}, done, 0);
  endtask

  initial begin
    clear     = 1'b1;
    start     = 1'b0;
    op        = OP_MUL;
    operand_a = '0;
    operand_b = '0;
    prev_hi   = '0;
    prev_lo   = '0;
    prev_dbz  = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_z_hi", z_hi, 0);
    check("reset_z_lo", z_lo, 0);
    check("reset_dbz", div_by_zero, 0);

    // clear wins over a simultaneous start
    start = 1'b1;
    @(posedge clock); #1;
    check("clear_beats_start_busy", busy, 0);
    start = 1'b0;
    clear = 1'b0;
    @(posedge clock); #1;
    check("idle_after_clear_busy", busy, 0);

    vecs[0]  = '{OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3]  = '{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{OP_MUL, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
    vecs[7]  = '{OP_DIV, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[8]  = '{OP_MUL, 32'h0000_3039, 32'hFFFF_FC18, 32'hFFFF_FFFF, 32'hFF43_A158, 1'b0};
    vecs[9]  = '{OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0};
    vecs[11] = '{OP_DIV, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[12] = '{OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[13] = '{OP_DIV, 32'h0000_0003, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0};

    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_dbz_hold", i), div_by_zero, prev_dbz);
      wait_done($sformatf("v%0d", i));
      check($sformatf("v%0d_z_hi", i), z_hi, vecs[i].hi);
      check($sformatf("v%0d_z_lo", i), z_lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
      prev_hi  = vecs[i].hi;
      prev_lo  = vecs[i].lo;
      prev_dbz = vecs[i].dbz;
      expect_pulse_end($sformatf("v%0d", i));
    end

    // A second start mid-operation must be ignored
    begin
      int done_at;
      done_at = 0;
      launch(OP_DIV, 32'd100, 32'd7);
      for (int c = 1; c <= 40; c++) begin
        if (c == 10) begin
          op        = OP_MUL;
          operand_a = 32'd9;
          operand_b = 32'd9;
          start     = 1'b1;
        end
        @(posedge clock); #1;
        if (c == 10) begin
          start = 1'b0;
          check("restart_busy", busy, 1);
        end
        if (done) begin
          done_at = c;
          break;
        end
      end
      check("restart_done_cycle", done_at, 34);
      check("restart_z_lo", z_lo, 32'd14);
      check("restart_z_hi", z_hi, 32'd2);
      prev_hi  = 32'd2;
      prev_lo  = 32'd14;
      prev_dbz = 1'b0;
      expect_pulse_end("restart");
    end

    // clear in the middle of a multiply aborts it silently
    begin
      int dones;
      dones = 0;
      launch(OP_MUL, 32'd3, 32'd4);
      for (int c = 1; c <= 15; c++) begin
        if (c == 15) clear = 1'b1;
        @(posedge clock); #1;
        if (done) dones++;
      end
      clear = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_z_hi", z_hi, 0);
      check("abort_z_lo", z_lo, 0);
      @(posedge clock); #1;
      if (done) dones++;
      check("abort_no_done", dones, 0);
      prev_hi = '0;
      prev_lo = '0;
      launch(OP_MUL, 32'd3, 32'd4);
      wait_done("after_abort");
      check("after_abort_z_lo", z_lo, 32'd12);
      check("after_abort_z_hi", z_hi, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative signed multiply/divide unit in the CPU datapath, directly downstream of the bus multiplexer. It captures its two operands from bus-driven registers, runs a 32-step radix-2 Booth multiply or non-restoring divide, and registers a 64-bit result. The ZHI/ZLO registers then load that result and drive it back onto the bus as the ZHI and ZLO sources.

## Interface

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = MUL, 1 = DIV; latched with start.
- operand_a  in  WIDTH  multiplicand / dividend (signed); latched with start.
- operand_b  in  WIDTH  multiplier / divisor (signed); latched with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when z_hi/z_lo update.
- z_hi  out  WIDTH  MUL: product[63:32]; DIV: remainder.
- z_lo  out  WIDTH  MUL: product[31:0]; DIV: quotient.
- div_by_zero  out  1  set with done when a DIV had operand_b == 0; held until next done.

## Operation

- FSM states and transitions:
  - IDLE -> ITER on start.
  - ITER runs 32 cycles, step counter 31..0, then -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE.
- MUL: Booth radix-2 on a {A, Q, q-1} accumulator. Each ITER: examine {Q[0], q-1}; add/subtract/none M to A; arithmetic shift right of {A, Q, q-1}. In FIX, pass through.
- DIV: non-restoring on magnitudes |a|, |b|, 33-bit partial remainder. In FIX:
  - apply the final remainder restore;
  - negate the quotient if the operand signs differ;
  - give the remainder the sign of the dividend (truncation toward zero).
- DIV overflow (0x80000000 / -1): quotient 0x80000000, remainder 0; no flag.
- Divide by zero: iterations still run (fixed latency). Result is forced to z_lo = 0xFFFFFFFF, z_hi = operand_a, div_by_zero = 1.
- start in any state other than IDLE is ignored; operands are not re-latched.
- z_hi, z_lo and div_by_zero change only on the DONE edge and hold otherwise.

## Timing

- start sampled high in IDLE at edge k: busy = 1 from k.
- ITER occupies edges k+1..k+32, FIX edge k+33.
- Results register and done = 1 at edge k+34.
- busy falls at edge k+34 (done and busy never both high). Back to IDLE at k+35; a new start is accepted at k+35 at the earliest.
- Latency is identical for MUL, DIV and divide by zero: 34 cycles from start to done.
- clear: at the next edge, state = IDLE, counter = 0, busy = 0, done = 0, z_hi = 0, z_lo = 0, div_by_zero = 0.
  - clear mid-operation aborts with no done pulse.
  - clear has priority over start on the same edge.

## Structure

- Package mul_div_pkg holds:
  - op encoding constants OP_MUL = 1'b0, OP_DIV = 1'b1;
  - state enum {IDLE, ITER, FIX, DONE};
  - ITER_COUNT = 32.
- One sub-module, mul_div_ctrl: the FSM plus step counter, emitting load/step/fix/done strobes. The arithmetic datapath stays in mul_div_unit.

## Test plan

- MUL 7 × −3 (a = 0x00000007, b = 0xFFFFFFFD) -> done at cycle 34; z_hi = 0xFFFFFFFF, z_lo = 0xFFFFFFEB.
- MUL 0x80000000 × 0x80000000 -> z_hi = 0x40000000, z_lo = 0x00000000. MUL 0xFFFFFFFF × 0xFFFFFFFF -> z_hi = 0, z_lo = 1.
- DIV −7 / 2 -> z_lo = 0xFFFFFFFD, z_hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> z_lo = 0x80000000, z_hi = 0, div_by_zero = 0.
- DIV 5 / 0 -> done at cycle 34; z_lo = 0xFFFFFFFF, z_hi = 0x00000005, div_by_zero = 1. A following MUL 2 × 3 clears the flag and gives z_lo = 6.
- start DIV 100 / 7; re-assert start with new operands at cycle 10 -> ignored; result z_lo = 14, z_hi = 2 at cycle 34.
- start MUL 3 × 4; assert clear at cycle 15 -> next edge busy = 0, z_hi = z_lo = 0, no done pulse. A new start at cycle 17 completes normally at cycle 51 with z_lo = 12.
